// File: rtl/sram_responder.sv
// sram_responder: clocked stand-in for a 16-bit asynchronous SRAM.
// Samples the SRAM_* pins, commits writes when WE_N is released and
// drives read data after READ_LAT stable cycles. Exposes read/write
// counters and a sticky WE/OE conflict flag.
// Optional feature macro: SRAM_RESP_BYTE_LANE_EN (UB_N/LB_N gate write
// lanes and the per-byte read drive). Undefined: full-word access.

module sram_resp_lane #(
  parameter int AW    = 18,
  parameter int VEC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [VEC_W-1:0] wdata,
  input  logic             ld,
  input  logic [AW-1:0]    raddr,
  output logic [VEC_W-1:0] rdata
);
  logic [VEC_W-1:0] mem [0:(1<<AW)-1];

  // byte-lane storage; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // capture read data once per completed read; held while driving
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (ld) rdata <= mem[raddr];
  end
endmodule

module sram_responder #(
  parameter int MEM_AW   = 18,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] SRAM_DQ,
  input  logic [17:0] SRAM_ADDR,
  input  logic        SRAM_UB_N,
  input  logic        SRAM_LB_N,
  input  logic        SRAM_WE_N,
  input  logic        SRAM_CE_N,
  input  logic        SRAM_OE_N,
  output logic        dq_valid,
  output logic [15:0] read_count,
  output logic [15:0] write_count,
  output logic        conflict
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 8;
  localparam logic [3:0] LAT = READ_LAT[3:0];

  // registered pin snapshot; controls are active-low as on the pins
  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] dq;
    logic        we;
    logic        oe;
    logic        ce;
    logic        ub;
    logic        lb;
  } pin_s;

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, READ_DRIVE} state_e;

  pin_s                             s;
  state_e                           state, nstate;
  logic [MEM_AW-1:0]                prev_addr, w_addr;
  logic [NUM_LANES-1:0][VEC_W-1:0]  w_data, dq_out;
  logic [NUM_LANES-1:0]             w_lanes, req_lanes, drv_lanes;
  logic [3:0]                       lat_cnt, lat_nxt, cur_cnt;
  logic                             wr_cond, rd_cond, addr_same;
  logic                             w_ld, commit, rd_ld;

  // single input register stage; all decisions below use these copies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) s <= '{addr: '0, dq: '0, we: 1'b1, oe: 1'b1, ce: 1'b1, ub: 1'b1, lb: 1'b1};
    else      s <= '{addr: SRAM_ADDR, dq: SRAM_DQ, we: SRAM_WE_N, oe: SRAM_OE_N,
                     ce: SRAM_CE_N, ub: SRAM_UB_N, lb: SRAM_LB_N};
  end

`ifdef SRAM_RESP_BYTE_LANE_EN
  assign req_lanes = {~s.ub, ~s.lb};
`else
  logic unused_lane_sel;
  assign unused_lane_sel = s.ub ^ s.lb;
  assign req_lanes = '1;
`endif

  // write wins over read: rd_cond requires WE_N high
  assign wr_cond   = ~s.ce & ~s.we;
  assign rd_cond   = ~s.ce & ~s.oe & s.we;
  assign addr_same = (s.addr[MEM_AW-1:0] == prev_addr);
  // stable-cycle count including the current sample
  assign cur_cnt   = (state == READ_WAIT && addr_same) ? lat_cnt + 4'd1 : 4'd1;
  // release the bus as soon as the registered pins stop asking for it
  assign dq_valid  = (state == READ_DRIVE) & rd_cond & addr_same;
  assign drv_lanes = {NUM_LANES{dq_valid}} & req_lanes;

  // next-state and strobe decode
  always_comb begin
    nstate  = state;
    lat_nxt = lat_cnt;
    w_ld    = 1'b0;
    commit  = 1'b0;
    rd_ld   = 1'b0;
    unique case (state)
      IDLE, READ_WAIT: begin
        if (wr_cond) begin
          nstate = WRITE;
          w_ld   = 1'b1;
        end else if (rd_cond) begin
          lat_nxt = cur_cnt;
          if (cur_cnt >= LAT) begin
            nstate = READ_DRIVE;
            rd_ld  = 1'b1;
          end else begin
            nstate = READ_WAIT;
          end
        end else begin
          nstate = IDLE;
        end
      end
      WRITE: begin
        if (wr_cond) begin
          w_ld = 1'b1;
        end else begin
          commit = 1'b1;
          if (rd_cond) begin
            nstate  = READ_WAIT;
            lat_nxt = 4'd1;
          end else begin
            nstate = IDLE;
          end
        end
      end
      READ_DRIVE: begin
        if (wr_cond) begin
          nstate = WRITE;
          w_ld   = 1'b1;
        end else if (!rd_cond) begin
          nstate = IDLE;
        end else if (!addr_same) begin
          nstate  = READ_WAIT;
          lat_nxt = 4'd1;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // state, latency counter, access counters and sticky conflict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      prev_addr   <= '0;
      read_count  <= '0;
      write_count <= '0;
      conflict    <= 1'b0;
    end else begin
      state     <= nstate;
      lat_cnt   <= lat_nxt;
      prev_addr <= s.addr[MEM_AW-1:0];
      if (rd_ld)  read_count  <= read_count + 16'd1;
      if (commit) write_count <= write_count + 16'd1;
      if (~s.ce & ~s.we & ~s.oe) conflict <= 1'b1;
    end
  end

  // pending write: last sample seen while WE_N was low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_addr  <= '0;
      w_data  <= '0;
      w_lanes <= '0;
    end else if (w_ld) begin
      w_addr  <= s.addr[MEM_AW-1:0];
      w_data  <= s.dq;
      w_lanes <= req_lanes;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    sram_resp_lane #(.AW(MEM_AW), .VEC_W(VEC_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .we    (commit & w_lanes[l]),
      .waddr (w_addr),
      .wdata (w_data[l]),
      .ld    (rd_ld),
      .raddr (s.addr[MEM_AW-1:0]),
      .rdata (dq_out[l])
    );
    assign SRAM_DQ[l*VEC_W +: VEC_W] = drv_lanes[l] ? dq_out[l] : {VEC_W{1'bz}};
  end
endmodule

// File: tb/tb_sram_responder.sv
// Randomized + directed bench for sram_responder against a pin-history
// reference model (run length of stable reads, write-burst end detection).
module tb_sram_responder;
  localparam int RL = 2;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
    logic        we, oe, ce, ub, lb;
  } pin_t;

  logic        clk = 1'b0;
  logic        rst;
  wire  [15:0] SRAM_DQ;
  logic [17:0] addr;
  logic [15:0] tb_dq;
  logic        ub_n, lb_n, we_n, ce_n, oe_n;
  logic        dq_valid, conflict;
  logic [15:0] read_count, write_count;

  // the bench owns the bus only while it holds WE_N low
  assign SRAM_DQ = we_n ? 16'hzzzz : tb_dq;

  sram_responder #(.MEM_AW(18), .READ_LAT(RL)) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(addr),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n), .dq_valid(dq_valid), .read_count(read_count),
    .write_count(write_count), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  logic [15:0] mm [int];
  logic [1:0]  wmask [int];
  pin_t        p1, p2;
  int          run1;
  logic [15:0] rc, wc;
  logic        cfe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic pin_t pins(input bit we, input bit oe, input bit ce,
                                input logic [17:0] a, input logic [15:0] d,
                                input bit ub, input bit lb);
    pin_t p;
    p.a = a; p.d = d; p.we = we; p.oe = oe; p.ce = ce; p.ub = ub; p.lb = lb;
    return p;
  endfunction

  function automatic bit is_wr(input pin_t p); return !p.ce && !p.we; endfunction
  function automatic bit is_rd(input pin_t p); return !p.ce && !p.oe && p.we; endfunction
  function automatic bit is_cf(input pin_t p); return !p.ce && !p.we && !p.oe; endfunction

  pin_t IDLE_P;

  task automatic mreset();
    p1 = IDLE_P; p2 = IDLE_P; run1 = 0; rc = '0; wc = '0; cfe = 1'b0;
  endtask

  task automatic mcommit(input pin_t p);
    logic [1:0]  ln;
    logic [15:0] v;
    ln = 2'b11;
`ifdef SRAM_RESP_BYTE_LANE_EN
    ln = {!p.ub, !p.lb};
`endif
    v = mm.exists(int'(p.a)) ? mm[int'(p.a)] : 16'h0;
    if (!wmask.exists(int'(p.a))) wmask[int'(p.a)] = 2'b00;
    if (ln[0]) v[7:0]  = p.d[7:0];
    if (ln[1]) v[15:8] = p.d[15:8];
    mm[int'(p.a)] = v;
    wmask[int'(p.a)] = wmask[int'(p.a)] | ln;
    wc = wc + 16'd1;
  endtask

  // one clock: apply pins, advance model at the edge, check #1 later
  task automatic cyc(input pin_t p);
    int          rk;
    logic [1:0]  dm;
    logic [15:0] ev;
    addr = p.a; tb_dq = p.d; we_n = p.we; oe_n = p.oe; ce_n = p.ce;
    ub_n = p.ub; lb_n = p.lb;
    @(posedge clk);
    if (run1 == RL) rc = rc + 16'd1;
    if (is_wr(p2) && !is_wr(p1)) mcommit(p2);
    if (is_cf(p1)) cfe = 1'b1;
    rk = is_rd(p) ? ((is_rd(p1) && p1.a == p.a) ? run1 + 1 : 1) : 0;
    p2 = p1; p1 = p; run1 = rk;
    #1;
    chk("dq_valid", dq_valid, rk > RL);
    chk("read_count", read_count, rc);
    chk("write_count", write_count, wc);
    chk("conflict", conflict, cfe);
    if (rk > RL && mm.exists(int'(p.a))) begin
      dm = wmask[int'(p.a)];
      ev = mm[int'(p.a)];
`ifdef SRAM_RESP_BYTE_LANE_EN
      dm = dm & {!p.ub, !p.lb};
`endif
      if (dm[0]) chk("dq_lo", SRAM_DQ[7:0], ev[7:0]);
      if (dm[1]) chk("dq_hi", SRAM_DQ[15:8], ev[15:8]);
    end
  endtask

  initial begin
    logic [15:0] rc_before;
    logic [15:0] exp_bl;
    pin_t        p;
    IDLE_P = pins(1, 1, 1, 18'h0, 16'h0, 0, 0);
    rst = 1'b0;
    addr = '0; tb_dq = '0; we_n = 1; oe_n = 1; ce_n = 1; ub_n = 1; lb_n = 1;
    mreset();

    // reset held with random pins
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      addr = 18'($urandom); tb_dq = 16'($urandom);
      we_n = 1'($urandom); oe_n = 1'($urandom); ce_n = 1'($urandom);
      ub_n = 1'($urandom); lb_n = 1'($urandom);
      chk("rst_vld", dq_valid, 0);
      chk("rst_rc", read_count, 0);
      chk("rst_wc", write_count, 0);
      chk("rst_cf", conflict, 0);
    end
    addr = '0; we_n = 1; oe_n = 1; ce_n = 1;
    @(posedge clk); #1;
    rst = 1'b1;
    mreset();

    // write BEEF at 0x10, then read with stable pins
    repeat (2) cyc(pins(0, 1, 0, 18'h10, 16'hBEEF, 0, 0));
    cyc(pins(1, 0, 0, 18'h10, 16'h0, 0, 0));
    cyc(pins(1, 0, 0, 18'h10, 16'h0, 0, 0));
    chk("beef_early", dq_valid, 0);
    cyc(pins(1, 0, 0, 18'h10, 16'h0, 0, 0));
    chk("beef_vld", dq_valid, 1);
    chk("beef_dq", SRAM_DQ, 16'hBEEF);
    repeat (2) cyc(pins(1, 0, 0, 18'h10, 16'h0, 0, 0));
    cyc(IDLE_P);
    chk("beef_wc", write_count, 1);
    chk("beef_rc", read_count, 1);

    // byte lanes: second write deselects the low byte
    repeat (2) cyc(pins(0, 1, 0, 18'h5, 16'h1234, 0, 0));
    cyc(IDLE_P);
    repeat (2) cyc(pins(0, 1, 0, 18'h5, 16'hAB00, 0, 1));
    cyc(IDLE_P);
    repeat (3) cyc(pins(1, 0, 0, 18'h5, 16'h0, 0, 0));
`ifdef SRAM_RESP_BYTE_LANE_EN
    exp_bl = 16'hAB34;
`else
    exp_bl = 16'hAB00;
`endif
    chk("lane_dq", SRAM_DQ, exp_bl);
    cyc(IDLE_P);

    // address churn: never drives, no counts
    rc_before = rc;
    for (int i = 0; i < 8; i++) begin
      cyc(pins(1, 0, 0, 18'(18'h20 + i), 16'h0, 0, 0));
      chk("churn_vld", dq_valid, 0);
    end
    cyc(IDLE_P);
    chk("churn_rc", read_count, rc_before);

    // randomized bursts; each burst ends with an idle cycle so the bus
    // is released before the bench drives it again
    for (int n = 0; n < 300; n++) begin
      int kind, len;
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      p = pins(1, 1, 0, 18'($urandom_range(0, 7)), 16'($urandom),
               1'($urandom), 1'($urandom));
      for (int i = 0; i < len; i++) begin
        case (kind)
          0: begin p.we = 0; p.oe = 1; p.d = 16'($urandom); end
          1: begin p.we = 1; p.oe = 0; end
          2: begin p.we = 1; p.oe = 0; p.a = 18'($urandom_range(0, 7)); end
          default: begin p.ce = 1; p.we = 1'($urandom); p.oe = 1'($urandom); end
        endcase
        cyc(p);
      end
      if (kind == 1) repeat (RL + 1) cyc(p);
      cyc(IDLE_P);
    end

    // conflict: WE and OE low together
    repeat (2) cyc(pins(0, 0, 0, 18'h7, 16'h00FF, 0, 0));
    chk("cf_set", conflict, 1);
    chk("cf_nodrv", dq_valid, 0);
    repeat (3) cyc(IDLE_P);
    chk("cf_sticky", conflict, 1);
    repeat (3) cyc(pins(1, 0, 0, 18'h7, 16'h0, 0, 0));
    chk("cf_mem", SRAM_DQ, 16'h00FF);
    cyc(IDLE_P);

    // reset in the middle of a write discards it
    repeat (2) cyc(pins(0, 1, 0, 18'h9, 16'h5A5A, 0, 0));
    repeat (2) cyc(IDLE_P);
    repeat (2) cyc(pins(0, 1, 0, 18'h9, 16'h1111, 0, 0));
    #2 rst = 1'b0;
    we_n = 1; oe_n = 1; ce_n = 1;
    mreset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rmw_wc", write_count, 0);
    chk("rmw_cf", conflict, 0);
    repeat (3) cyc(pins(1, 0, 0, 18'h9, 16'h0, 0, 0));
    chk("rmw_dq", SRAM_DQ, 16'h5A5A);
    chk("rmw_wc2", write_count, 0);
    cyc(IDLE_P);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
# sram_responder

Clocked, synthesizable responder for the 16-bit asynchronous SRAM pin interface driven by the memory-stage SRAM controller. It samples the SRAM_* control, address and data pins and commits byte-lane writes on WE_N release. It returns read data on SRAM_DQ after a configurable number of stable cycles. It sits at the far end of the SRAM pins in the simulation top and in the on-FPGA loopback build, replacing the physical chip, and exposes access counters and a protocol-conflict flag for verification.

## Interface
- MEM_AW, 18: address bits used to index the array; depth = 2^MEM_AW words; SRAM_ADDR bits above MEM_AW-1 are ignored.
- READ_LAT, 2: consecutive stable read cycles before DQ is driven; legal range 1..15.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- SRAM_DQ  inout  16  data bus; driven only while dq_valid=1, otherwise high-Z.
- SRAM_ADDR  in  18  word address.
- SRAM_UB_N  in  1  upper-byte select, active-low.
- SRAM_LB_N  in  1  lower-byte select, active-low.
- SRAM_WE_N  in  1  write enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- dq_valid  out  1  responder currently driving SRAM_DQ.
- read_count  out  16  completed reads, wraps at 16'hFFFF.
- write_count  out  16  committed writes, wraps at 16'hFFFF.
- conflict  out  1  sticky; set on simultaneous WE_N=0 and OE_N=0 with CE_N=0.

## Operation
- Input stage: all SRAM_* inputs and SRAM_DQ are registered once per clock (s_addr, s_dq, s_we, s_oe, s_ce, s_ub, s_lb). All decisions use the registered copies.
- States: IDLE, WRITE, READ_WAIT, READ_DRIVE.
- IDLE: s_ce=1, or neither a write nor a read condition holds. DQ high-Z.
- WRITE: entered when s_ce=0 and s_we=0. Each cycle, latch w_addr, w_data and w_lanes from the registered copies. The commit happens in the first cycle that s_we=1 or s_ce=1 after WRITE. It writes w_data into mem[w_addr] for the selected lanes, increments write_count, then moves to IDLE, or to READ_WAIT if the read condition holds.
- READ_WAIT: entered when s_ce=0, s_oe=0 and s_we=1. A 4-bit lat_cnt starts at 1 and counts consecutive cycles with an unchanged s_addr. When lat_cnt = READ_LAT, move to READ_DRIVE, load dq_out = mem[s_addr], and increment read_count once.
- READ_DRIVE: DQ driven with dq_out, and dq_valid=1. An s_addr change returns to READ_WAIT with lat_cnt=1 and DQ high-Z. Loss of the read condition returns to IDLE and releases DQ.
- Priority: WRITE beats READ. If s_we=0, s_oe=0 and s_ce=0 together: conflict is set, WRITE is taken, and DQ is not driven.
- Memory contents are not cleared by reset; the array is undefined until written.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, dq_valid=0, SRAM_DQ=Z, read_count=0, write_count=0, conflict=0, lat_cnt=0, input registers cleared with controls inactive (1).
- Write latency: pins to registered copy takes 1 cycle. The commit lands on the clock after WE_N is first sampled high. Read-after-write to the same address returns the new data.
- Read latency: DQ is valid READ_LAT+1 clocks after OE_N/CE_N/ADDR are presented stable (1 input register + READ_LAT). It then holds every cycle while the inputs stay stable; no further count increments.
- Address changes every cycle with READ_LAT≥2: DQ is never driven, and read_count does not increment.
- WE_N falling while in READ_DRIVE: DQ is released in the same cycle the registered s_we=0 is seen, and the state is WRITE.
- rst asserted mid-write: the pending commit is discarded.
- Counter wrap: 16'hFFFF + 1 gives 16'h0000, and no flag.

## Configuration
- SRAM_RESP_BYTE_LANE_EN defined: UB_N/LB_N gate write lanes; during reads, unselected byte lanes of SRAM_DQ stay high-Z; a write with both lanes deselected commits nothing but still increments write_count.
- Not defined: UB_N/LB_N are ignored; every write commits the full 16-bit word; reads drive all 16 bits.

## Test plan
- Reset: hold rst=0 with random pins -> SRAM_DQ=Z, dq_valid=0, read_count=0, write_count=0, conflict=0.
- Write then read: write 16'hBEEF at 18'h00010 (WE_N low for 2 cycles), then read the same address held stable with READ_LAT=2 -> DQ=16'hBEEF exactly 3 clocks after presentation; write_count=1, read_count=1.
- Byte lanes (macro defined): write 16'h1234 at address 5, then write 16'hAB00 with LB_N=1 -> read returns 16'hAB34; same sequence without the macro -> 16'hAB00.
- Address churn: change the address every cycle for 8 cycles with OE_N=0 -> dq_valid stays 0, and read_count is unchanged.
- Conflict: drive CE_N=0, WE_N=0, OE_N=0 with DQ=16'h00FF at address 7 -> conflict=1 and stays set, DQ not driven, mem[7]=16'h00FF after WE_N rises.
- Reset mid-write: assert rst while WE_N=0 at address 9, then read address 9 -> old contents, write_count=0.
